// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding an 8N1 serial transmitter (LSB first, idle-high line).
// A synchronized block input holds off new frames without disturbing one in flight.
module serial_tx_fifo #(
    parameter int CLK_PER_BIT = 100,
    parameter int DEPTH       = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       new_i,
    output logic       busy_o,
    input  logic       block_i,
    output logic       tx_o,
    output logic       idle_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = 16;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
    localparam logic [CW-1:0]   BIT_LAST = CW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            r_blk_meta;
    logic            r_blk_sync;
    state_t          r_state;
    logic [CW-1:0]   r_bit_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_tx;

    state_t          w_state_next;
    logic [CW-1:0]   w_cnt_next;
    logic [2:0]      w_idx_next;
    logic            w_tx_next;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;
    logic            w_bit_done;

    assign w_full     = (r_count == FULL_CNT);
    assign w_wr       = new_i && !w_full;
    assign w_bit_done = (r_bit_cnt == BIT_LAST);

    assign busy_o = w_full;
    assign idle_o = (r_state == S_IDLE) && (r_count == '0);
    assign tx_o   = r_tx;

    // NOTE: the storage array has no reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Synchronizer comes out of reset in the blocked state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_blk_meta <= 1'b1;
            r_blk_sync <= 1'b1;
        end else begin
            r_blk_meta <= block_i;
            r_blk_sync <= r_blk_meta;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_bit_cnt + CW'(1);
        w_idx_next   = r_idx;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_idx_next = '0;
                w_tx_next  = 1'b1;
                if ((r_count != '0) && !r_blk_sync) begin
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                    w_pop        = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_tx_next    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_next = '0;
                    if (r_idx == 3'd7) begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                        w_tx_next  = r_shift[r_idx + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                    w_tx_next    = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_tx      <= w_tx_next;
            if (w_pop) r_shift <= r_mem[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo: a line monitor captures every frame as 40
// per-cycle samples and the stimulus compares them with hand-built waveforms.
module tb_serial_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] data_i;
    logic       new_i;
    logic       block_i;
    logic       busy_o;
    logic       tx_o;
    logic       idle_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] frames_q [$];
    int          gaps_q   [$];

    serial_tx_fifo #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .new_i   (new_i),
        .busy_o  (busy_o),
        .block_i (block_i),
        .tx_o    (tx_o),
        .idle_o  (idle_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Start bit (4 samples), 8 data bits LSB first, stop bit; sample 0 is bit 0 of the vector.
    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [39:0] f;
        for (int i = 0; i < 40; i++) begin
            int k;
            k    = i / CPB;
            f[i] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        end
        return f;
    endfunction

    function automatic logic [7:0] seq_byte(input int i);
        return 8'(i * 37 + 5);
    endfunction

    // Line monitor: gap counts idle-high samples since the last frame (or reset).
    initial begin : line_mon
        logic [39:0] cap;
        int          cap_n;
        int          gap;
        cap   = '1;
        cap_n = 0;
        gap   = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                cap_n = 0;
                gap   = 0;
            end else if (cap_n == 0) begin
                if (tx_o == 1'b0) begin
                    cap[0] = 1'b0;
                    cap_n  = 1;
                end else begin
                    gap++;
                end
            end else begin
                cap[cap_n] = tx_o;
                cap_n++;
                if (cap_n == 40) begin
                    frames_q.push_back(cap);
                    gaps_q.push_back(gap);
                    cap_n = 0;
                    gap   = 0;
                end
            end
        end
    end

    task automatic wr(input logic [7:0] b);
        data_i = b;
        new_i  = 1'b1;
        @(negedge clk);
        new_i  = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input logic [7:0] b, input int exp_gap);
        int t;
        t = 0;
        while (frames_q.size() == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (frames_q.size() == 0) begin
            check({tag, "_timeout"}, frames_q.size(), 1);
        end else begin
            logic [39:0] f;
            int          g;
            f = frames_q.pop_front();
            g = gaps_q.pop_front();
            check(tag, f, frame_bits(b));
            if (exp_gap >= 0) check({tag, "_gap"}, g, exp_gap);
        end
    endtask

    task automatic hold_high(input string tag, input int n);
        int lows;
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx_o == 1'b0) lows++;
        end
        check(tag, lows, 0);
    endtask

    task automatic refill_wrap();
        for (int w = DEPTH; w < 3 * DEPTH; w++) begin
            int t;
            t = 0;
            while (busy_o && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (busy_o) check("wrap_refill_timeout", busy_o, 0);
            wr(seq_byte(w));
        end
    endtask

    task automatic recv_wrap();
        for (int k = 0; k < 3 * DEPTH; k++)
            wait_frame($sformatf("wrap%0d", k), seq_byte(k), (k == 0) ? -1 : 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        rst_i   = 1'b1;
        new_i   = 1'b0;
        block_i = 1'b0;
        data_i  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_idle", idle_o, 1);
        rst_i = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte: write at edge N, start bit from edge N+1.
        data_i = 8'hA5;
        new_i  = 1'b1;
        @(negedge clk);
        new_i = 1'b0;
        check("lat_n_tx", tx_o, 1);
        check("lat_n_idle", idle_o, 0);
        @(negedge clk);
        check("lat_n1_tx", tx_o, 0);
        wait_frame("a5", 8'hA5, -1);
        @(negedge clk);
        check("a5_idle", idle_o, 1);

        // Fill while blocked; fifth write dropped.
        block_i = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            data_i = 8'(k);
            new_i  = 1'b1;
            @(negedge clk);
            if (k == 3) check("fill3_busy", busy_o, 0);
            if (k == 4) check("fill4_busy", busy_o, 1);
        end
        new_i = 1'b0;
        check("fill5_busy", busy_o, 1);
        hold_high("blocked_tx", 12);
        block_i = 1'b0;
        @(negedge clk);
        check("unblk_e1", tx_o, 1);
        @(negedge clk);
        check("unblk_e2", tx_o, 1);
        @(negedge clk);
        check("unblk_e3", tx_o, 0);
        wait_frame("f01", 8'h01, -1);
        wait_frame("f02", 8'h02, 1);
        wait_frame("f03", 8'h03, 1);
        wait_frame("f04", 8'h04, 1);
        @(negedge clk);
        check("f04_idle", idle_o, 1);
        hold_high("no_f05", 10);

        // Block asserted mid-frame: frame completes, next waits for two unblocked edges.
        block_i = 1'b1;
        repeat (3) @(negedge clk);
        wr(8'h5A);
        wr(8'hC3);
        block_i = 1'b0;
        repeat (20) @(negedge clk);
        block_i = 1'b1;
        wait_frame("blk_f1", 8'h5A, -1);
        hold_high("blk_hold", 12);
        block_i = 1'b0;
        @(negedge clk);
        check("blk_rel_e1", tx_o, 1);
        @(negedge clk);
        check("blk_rel_e2", tx_o, 1);
        @(negedge clk);
        check("blk_rel_e3", tx_o, 0);
        wait_frame("blk_f2", 8'hC3, -1);

        // Write on the pop edge while full is dropped; next cycle is accepted.
        block_i = 1'b1;
        repeat (3) @(negedge clk);
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        wr(8'h44);
        check("pre_pop_full", busy_o, 1);
        block_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pop_edge_busy", busy_o, 1);
        data_i = 8'h77;
        new_i  = 1'b1;
        @(negedge clk);
        new_i = 1'b0;
        check("pop_started", tx_o, 0);
        check("after_pop_busy", busy_o, 0);
        wr(8'h88);
        check("refill_busy", busy_o, 1);
        wait_frame("p11", 8'h11, -1);
        wait_frame("p22", 8'h22, 1);
        wait_frame("p33", 8'h33, 1);
        wait_frame("p44", 8'h44, 1);
        wait_frame("p88", 8'h88, 1);
        hold_high("no_77", 10);

        // Reset during data bit 3 aborts the frame and discards the queued byte.
        data_i = 8'h96;
        new_i  = 1'b1;
        @(negedge clk);
        data_i = 8'hE7;
        @(negedge clk);
        new_i = 1'b0;
        check("r_start", tx_o, 0);
        repeat (17) @(negedge clk);
        check("r_bit3", tx_o, 0);
        rst_i = 1'b1;
        #1;
        check("r_tx", tx_o, 1);
        check("r_idle", idle_o, 1);
        check("r_busy", busy_o, 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        check("r_no_frame", frames_q.size(), 0);
        hold_high("r_discard", 12);
        wr(8'h3C);
        wait_frame("r_3c", 8'h3C, -1);

        // Continuous refill across 3*DEPTH bytes exercises pointer wrap.
        block_i = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < DEPTH; k++) wr(seq_byte(k));
        block_i = 1'b0;
        fork
            refill_wrap();
            recv_wrap();
        join
        @(negedge clk);
        check("wrap_idle", idle_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx_fifo.md
SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 100, giving clk_i cycles per serial bit (500 kbaud at 50 MHz); legal range 2..65535.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving byte-FIFO depth; power of two, 2..16.
REQ-003 The block SHALL have port clk_i, input, 1 bit: system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_i, input, 8 bits: byte to transmit, sampled when new_i is high.
REQ-006 The block SHALL have port new_i, input, 1 bit: single-cycle write strobe for data_i.
REQ-007 The block SHALL have port busy_o, output, 1 bit: FIFO full; writes are not accepted.
REQ-008 The block SHALL have port block_i, input, 1 bit: asynchronous flow control from the downstream receiver; high means do not start a new frame.
REQ-009 The block SHALL have port tx_o, output, 1 bit: serial line, idle high, 8N1, LSB first.
REQ-010 The block SHALL have port idle_o, output, 1 bit: high when the FIFO is empty and no frame is in progress.

Function
REQ-011 The block SHALL accept a write at a clock edge iff new_i=1 and FIFO count<DEPTH at that edge; writes while full SHALL be silently dropped, and FIFO contents SHALL be unchanged.
REQ-012 busy_o SHALL be combinational: busy_o = (count==DEPTH).
REQ-013 A simultaneous accepted write and pop in the same cycle SHALL leave count unchanged; a pop with count==0 SHALL never occur.
REQ-014 Read and write pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, and count SHALL be log2(DEPTH)+1 bits.
REQ-015 block_i SHALL pass through a two-flop synchronizer before use.
REQ-016 Transmit FSM states SHALL be IDLE, START, DATA and STOP.
  - IDLE: tx_o=1.
  - IDLE -> START when count>0 and synchronized block=0; the FIFO head is popped into the shift register on the same edge.
REQ-017 START SHALL drive tx_o=0 for CLK_PER_BIT cycles, then move to DATA.
REQ-018 DATA SHALL drive bits 0..7 for CLK_PER_BIT cycles each, tracked by a 3-bit index, then move to STOP.
REQ-019 STOP SHALL drive tx_o=1 for CLK_PER_BIT cycles, then move to IDLE; with data waiting and block low, the next START SHALL begin on the following edge, giving exactly one idle cycle between frames.
REQ-020 tx_o SHALL be registered, and the bit-period counter SHALL reset to 0 on every state or bit change.
REQ-021 block_i SHALL be evaluated only in IDLE; assertion mid-frame SHALL NOT truncate or stretch the current frame.
REQ-022 Latency: with the FIFO empty, the FSM in IDLE and the synchronized block low, a write accepted at edge N SHALL drive tx_o low from edge N+1 onward.
REQ-023 idle_o SHALL be combinational: (state==IDLE) && (count==0).

Reset
REQ-024 While rst_i is high, the block SHALL hold: tx_o=1, busy_o=0, idle_o=1, state=IDLE, count=0, pointers=0, bit counter=0, index=0, and both synchronizer flops=1 (blocked).
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with tx_o=1 asynchronously, and SHALL discard all FIFO contents.
REQ-026 After reset release, no frame SHALL start until two edges have passed with block_i low.

Verification
REQ-027 With CLK_PER_BIT=4, block_i=0, write 0xA5 -> tx_o low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles; idle_o returns to 1.
REQ-028 With block_i=1 and DEPTH=4, write 0x01..0x05 on consecutive cycles -> busy_o=1 after the 4th write, 0x05 is dropped, and tx_o stays 1; after deasserting block_i, frames 0x01..0x04 are sent in order with one idle cycle between them.
REQ-029 Assert block_i in the middle of frame 1 of 2 queued frames -> frame 1 completes intact and frame 2 does not start until block_i has been low for 2 edges.
REQ-030 With the FIFO full and a frame starting (pop), assert new_i with 0x77 on the pop edge -> the write is dropped because busy_o=1 at that edge and count becomes DEPTH-1; a write on the next cycle is accepted.
REQ-031 Assert rst_i during DATA bit 3 -> tx_o=1 immediately, idle_o=1, busy_o=0; a write of 0x3C after release plus 2 unblocked cycles is transmitted correctly.
REQ-032 Write exactly DEPTH bytes, then continuously refill as each pop occurs -> pointer wrap-around yields an uncorrupted byte sequence across 3×DEPTH bytes.
